// File: rtl/cpu_stat_pkg.sv
// Shared state encoding and halt-cause codes for the instruction sequencer.
package cpu_stat_pkg;

  localparam int STATE_W = 8;

  // Bit positions inside the one-hot state vector.
  localparam int S_IDLE = 0;
  localparam int S_PC   = 1;
  localparam int S_IF   = 2;
  localparam int S_DC   = 3;
  localparam int S_EX   = 4;
  localparam int S_MA   = 5;
  localparam int S_WB   = 6;
  localparam int S_WFI  = 7;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 8'b0000_0001,
    ST_PC   = 8'b0000_0010,
    ST_IF   = 8'b0000_0100,
    ST_DC   = 8'b0000_1000,
    ST_EX   = 8'b0001_0000,
    ST_MA   = 8'b0010_0000,
    ST_WB   = 8'b0100_0000,
    ST_WFI  = 8'b1000_0000
  } state_t;

  localparam logic [1:0] HALT_RESET  = 2'd0;
  localparam logic [1:0] HALT_QUIT   = 2'd1;
  localparam logic [1:0] HALT_STEP   = 2'd2;
  localparam logic [1:0] HALT_EBREAK = 2'd3;

endpackage

// File: rtl/cpu_req_latch.sv
// Sticky request bit, set dominates clear; 1-cycle set-to-q latency, no backpressure.
module cpu_req_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic clr,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (set) begin
      q <= 1'b1;
    end else if (clr) begin
      q <= 1'b0;
    end
  end

endmodule

// File: rtl/cpu_stat_ctrl.sv
// One-hot PC/IF/DC/EX/MA/WB sequencer with start/step/quit/ebreak/WFI control.
// Strobes are state decodes (6 cycles per unstalled instruction); stall holds IF and MA only.
module cpu_stat_ctrl
  import cpu_stat_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_start,
  input  logic                 step_cmd,
  input  logic                 quit_cmd,
  input  logic                 stall,
  input  logic                 cmd_ebreak_ex,
  input  logic                 cmd_wfi_ex,
  input  logic                 interrupt_wake,
  output logic                 cpu_stat_pc,
  output logic                 cpu_stat_if,
  output logic                 cpu_stat_dc,
  output logic                 cpu_stat_ex,
  output logic                 cpu_stat_ma,
  output logic                 cpu_stat_wb,
  output logic                 cpu_idle,
  output logic                 cpu_sleep,
  output logic                 retire,
  output logic [1:0]           halt_cause,
  output logic [INSTRET_W-1:0] instret
);

  state_t               state;
  logic                 step_mode;
  logic                 quit_pend;
  logic                 ebreak_pend;
  logic                 wfi_pend;
  logic [1:0]           halt_cause_q;
  logic [INSTRET_W-1:0] instret_q;

  logic wb_halt;
  logic wfi_quit;
  logic enter_idle;

  assign wb_halt    = state[S_WB] & (quit_pend | ebreak_pend | step_mode);
  assign wfi_quit   = state[S_WFI] & (quit_cmd | quit_pend);
  assign enter_idle = wb_halt | wfi_quit;

  cpu_req_latch u_quit_pend (
    .clk   (clk),
    .rst_n (rst_n),
    .set   (quit_cmd & ~state[S_IDLE]),
    .clr   (enter_idle),
    .q     (quit_pend)
  );

  cpu_req_latch u_ebreak_pend (
    .clk   (clk),
    .rst_n (rst_n),
    .set   (cmd_ebreak_ex & state[S_EX]),
    .clr   (enter_idle),
    .q     (ebreak_pend)
  );

  // wfi_pend is per-instruction: every WB exit drops it.
  cpu_req_latch u_wfi_pend (
    .clk   (clk),
    .rst_n (rst_n),
    .set   (cmd_wfi_ex & state[S_EX]),
    .clr   (enter_idle | state[S_WB]),
    .q     (wfi_pend)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      step_mode    <= 1'b0;
      halt_cause_q <= HALT_RESET;
      instret_q    <= '0;
    end else begin
      if (state[S_WB]) begin
        instret_q <= instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
      end
      unique case (state)
        ST_IDLE: begin
          if (step_cmd) begin
            state     <= ST_PC;
            step_mode <= 1'b1;
          end else if (cpu_start) begin
            state     <= ST_PC;
            step_mode <= 1'b0;
          end
        end
        ST_PC: state <= ST_IF;
        ST_IF: if (!stall) state <= ST_DC;
        ST_DC: state <= ST_EX;
        ST_EX: state <= ST_MA;
        ST_MA: if (!stall) state <= ST_WB;
        ST_WB: begin
          if (quit_pend) begin
            state        <= ST_IDLE;
            halt_cause_q <= HALT_QUIT;
            step_mode    <= 1'b0;
          end else if (ebreak_pend) begin
            state        <= ST_IDLE;
            halt_cause_q <= HALT_EBREAK;
            step_mode    <= 1'b0;
          end else if (step_mode) begin
            state        <= ST_IDLE;
            halt_cause_q <= HALT_STEP;
            step_mode    <= 1'b0;
          end else if (wfi_pend && !interrupt_wake) begin
            state <= ST_WFI;
          end else begin
            state <= ST_PC;
          end
        end
        ST_WFI: begin
          if (quit_cmd || quit_pend) begin
            state        <= ST_IDLE;
            halt_cause_q <= HALT_QUIT;
            step_mode    <= 1'b0;
          end else if (interrupt_wake) begin
            state <= ST_PC;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cpu_stat_pc = state[S_PC];
  assign cpu_stat_if = state[S_IF];
  assign cpu_stat_dc = state[S_DC];
  assign cpu_stat_ex = state[S_EX];
  assign cpu_stat_ma = state[S_MA];
  assign cpu_stat_wb = state[S_WB];
  assign cpu_idle    = state[S_IDLE];
  assign cpu_sleep   = state[S_WFI];
  assign retire      = state[S_WB];
  assign halt_cause  = halt_cause_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_cpu_stat_ctrl.sv
// Self-checking bench: expected stage traces are built per instruction and compared cycle by cycle.
`timescale 1ns/1ps
module tb_cpu_stat_ctrl;

  localparam int I_IDLE = 0;
  localparam int I_PC   = 1;
  localparam int I_IF   = 2;
  localparam int I_DC   = 3;
  localparam int I_EX   = 4;
  localparam int I_MA   = 5;
  localparam int I_WB   = 6;
  localparam int I_WFI  = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, cpu_start, step_cmd, quit_cmd, stall, cmd_ebreak_ex, cmd_wfi_ex, interrupt_wake;

  logic s_pc, s_if, s_dc, s_ex, s_ma, s_wb, idle, sleep, retire;
  logic [1:0]  halt;
  logic [31:0] instret;
  logic t_pc, t_if, t_dc, t_ex, t_ma, t_wb, idle4, sleep4, retire4;
  logic [1:0]  halt4;
  logic [3:0]  instret4;

  logic [7:0] vec, vec4;
  assign vec  = {sleep, s_wb, s_ma, s_ex, s_dc, s_if, s_pc, idle};
  assign vec4 = {sleep4, t_wb, t_ma, t_ex, t_dc, t_if, t_pc, idle4};

  cpu_stat_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cpu_start(cpu_start), .step_cmd(step_cmd),
    .quit_cmd(quit_cmd), .stall(stall), .cmd_ebreak_ex(cmd_ebreak_ex),
    .cmd_wfi_ex(cmd_wfi_ex), .interrupt_wake(interrupt_wake),
    .cpu_stat_pc(s_pc), .cpu_stat_if(s_if), .cpu_stat_dc(s_dc), .cpu_stat_ex(s_ex),
    .cpu_stat_ma(s_ma), .cpu_stat_wb(s_wb), .cpu_idle(idle), .cpu_sleep(sleep),
    .retire(retire), .halt_cause(halt), .instret(instret)
  );

  // Narrow counter instance so that wrap-around is reachable in a short run.
  cpu_stat_ctrl #(.INSTRET_W(4)) dut_w4 (
    .clk(clk), .rst_n(rst_n), .cpu_start(cpu_start), .step_cmd(step_cmd),
    .quit_cmd(quit_cmd), .stall(stall), .cmd_ebreak_ex(cmd_ebreak_ex),
    .cmd_wfi_ex(cmd_wfi_ex), .interrupt_wake(interrupt_wake),
    .cpu_stat_pc(t_pc), .cpu_stat_if(t_if), .cpu_stat_dc(t_dc), .cpu_stat_ex(t_ex),
    .cpu_stat_ma(t_ma), .cpu_stat_wb(t_wb), .cpu_idle(idle4), .cpu_sleep(sleep4),
    .retire(retire4), .halt_cause(halt4), .instret(instret4)
  );

  int tests = 0;
  int fails = 0;
  longint unsigned ret_exp = 0;

  typedef struct {
    int st;
    bit stall, quit, start, step, ebk, wfi, wake;
  } cyc_t;
  cyc_t q[$];

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cpu_start = 0; step_cmd = 0; quit_cmd = 0; stall = 0;
    cmd_ebreak_ex = 0; cmd_wfi_ex = 0; interrupt_wake = 0;
  endtask

  task automatic push(int st, bit stl, bit qt, bit str, bit stp, bit ebk, bit wf, bit wk);
    cyc_t c;
    c.st = st; c.stall = stl; c.quit = qt; c.start = str; c.step = stp;
    c.ebk = ebk; c.wfi = wf; c.wake = wk;
    q.push_back(c);
  endtask

  // One instruction: stall only matters in IF/MA, other inputs are random noise outside the stage that samples them.
  task automatic push_instr(int sif, int sma, int quit_st, bit ebk, bit wfi, bit wake_wb);
    push(I_PC, rb(), quit_st == I_PC, rb(), rb(), rb(), rb(), rb());
    for (int i = 0; i <= sif; i++)
      push(I_IF, i < sif, (quit_st == I_IF) && (i == 0), rb(), rb(), rb(), rb(), rb());
    push(I_DC, rb(), quit_st == I_DC, rb(), rb(), rb(), rb(), rb());
    push(I_EX, rb(), quit_st == I_EX, rb(), rb(), ebk, wfi, rb());
    for (int i = 0; i <= sma; i++)
      push(I_MA, i < sma, (quit_st == I_MA) && (i == 0), rb(), rb(), rb(), rb(), rb());
    push(I_WB, rb(), 1'b0, rb(), rb(), rb(), rb(), wake_wb);
  endtask

  task automatic run_expect(string name);
    while (q.size() > 0) begin
      cyc_t c;
      logic [7:0] ev;
      c = q.pop_front();
      ev = 8'b1 << c.st;
      tests++;
      if (vec !== ev) begin
        fails++;
        $display("FAIL %s stage: got %b want %b", name, vec, ev);
      end
      tests++;
      if (vec4 !== ev) begin
        fails++;
        $display("FAIL %s stage_w4: got %b want %b", name, vec4, ev);
      end
      tests++;
      if (retire !== (c.st == I_WB)) begin
        fails++;
        $display("FAIL %s retire: got %b want %b", name, retire, c.st == I_WB);
      end
      tests++;
      if (instret !== ret_exp[31:0] || instret4 !== ret_exp[3:0]) begin
        fails++;
        $display("FAIL %s instret: got %0d/%0d want %0d/%0d", name, instret, instret4,
                 ret_exp[31:0], ret_exp[3:0]);
      end
      stall = c.stall; quit_cmd = c.quit; cpu_start = c.start; step_cmd = c.step;
      cmd_ebreak_ex = c.ebk; cmd_wfi_ex = c.wfi; interrupt_wake = c.wake;
      tick();
      if (c.st == I_WB) ret_exp++;
    end
    clear_inputs();
  endtask

  task automatic check_halt(string name, logic [1:0] want);
    tests++;
    if (halt !== want || halt4 !== want) begin
      fails++;
      $display("FAIL %s halt_cause: got %0d/%0d want %0d", name, halt, halt4, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    #12;
    tests++;
    if (vec !== 8'b0000_0001 || vec4 !== 8'b0000_0001 || retire !== 1'b0) begin
      fails++;
      $display("FAIL reset outputs: got %b ret %b want 00000001 ret 0", vec, retire);
    end
    tests++;
    if (instret !== 32'd0 || instret4 !== 4'd0) begin
      fails++;
      $display("FAIL reset instret: got %0d want 0", instret);
    end
    check_halt("reset", 2'd0);
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_start_basic();
    push(I_IDLE, 0, 0, 1, 0, 0, 0, 0);
    push_instr(0, 0, -1, 0, 0, rb());
    push_instr(0, 0, I_DC, 0, 0, rb());
    push(I_IDLE, 0, 0, 0, 0, 0, 0, 0);
    push(I_IDLE, 0, 0, 0, 0, 0, 0, 0);
    run_expect("start_basic");
    check_halt("start_basic", 2'd1);
  endtask

  task automatic test_stall();
    int n;
    n = $urandom_range(3, 5);
    push(I_IDLE, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) begin
      int sif, sma, qs;
      sif = (i == 0) ? 3 : $urandom_range(0, 3);
      sma = (i == 0) ? 2 : $urandom_range(0, 3);
      qs  = (i == n - 1) ? $urandom_range(I_PC, I_MA) : -1;
      push_instr(sif, sma, qs, 0, 0, rb());
    end
    push(I_IDLE, 1, 0, 0, 0, 0, 0, 0);
    run_expect("stall");
    check_halt("stall", 2'd1);
  endtask

  task automatic test_quit_in_idle();
    push(I_IDLE, 0, 1, 0, 0, 0, 0, 0);
    push(I_IDLE, 0, 0, 1, 0, 0, 0, 0);
    push_instr(0, 1, -1, 0, 0, rb());
    push_instr(1, 0, I_EX, 0, 0, rb());
    push(I_IDLE, 0, 0, 0, 0, 0, 0, 0);
    run_expect("quit_in_idle");
    check_halt("quit_in_idle", 2'd1);
  endtask

  task automatic test_step();
    push(I_IDLE, 0, 0, 1, 1, 0, 0, 0);
    push_instr($urandom_range(0, 2), $urandom_range(0, 2), -1, 0, 0, rb());
    push(I_IDLE, 0, 0, 0, 0, 0, 0, 0);
    push(I_IDLE, 0, 0, 0, 0, 0, 0, 0);
    run_expect("step");
    check_halt("step", 2'd2);
  endtask

  task automatic test_ebreak();
    push(I_IDLE, 0, 0, 1, 0, 0, 0, 0);
    push_instr(0, 0, I_DC, 1, 0, rb());
    push(I_IDLE, 0, 0, 0, 0, 0, 0, 0);
    run_expect("ebreak_quit");
    check_halt("ebreak_quit", 2'd1);
    push(I_IDLE, 0, 0, 1, 0, 0, 0, 0);
    push_instr(0, 0, -1, 0, 0, rb());
    push_instr(1, 1, -1, 1, 0, rb());
    push(I_IDLE, 0, 0, 0, 0, 0, 0, 0);
    run_expect("ebreak");
    check_halt("ebreak", 2'd3);
  endtask

  task automatic test_wfi();
    int k;
    k = $urandom_range(1, 5);
    push(I_IDLE, 0, 0, 1, 0, 0, 0, 0);
    push_instr(0, 0, -1, 0, 1, 0);
    for (int j = 0; j < k; j++)
      push(I_WFI, rb(), 0, rb(), rb(), rb(), rb(), j == k - 1);
    push_instr(0, 0, -1, 0, 1, 1);
    push_instr(0, 0, I_IF, 0, 0, rb());
    push(I_IDLE, 0, 0, 0, 0, 0, 0, 0);
    run_expect("wfi");
    check_halt("wfi", 2'd1);
  endtask

  task automatic test_back_to_back();
    push(I_IDLE, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      push_instr(0, 0, (i == 19) ? $urandom_range(I_PC, I_MA) : -1, 0, 0, rb());
    push(I_IDLE, 0, 0, 0, 0, 0, 0, 0);
    run_expect("back_to_back");
    tests++;
    if (ret_exp < 16 || instret4 !== ret_exp[3:0]) begin
      fails++;
      $display("FAIL wrap instret_w4: got %0d want %0d (total %0d)", instret4, ret_exp[3:0], ret_exp);
    end
  endtask

  task automatic test_wfi_quit();
    push(I_IDLE, 0, 0, 1, 0, 0, 0, 0);
    push_instr(1, 0, -1, 0, 1, 0);
    push(I_WFI, 1, 0, 1, 0, 0, 0, 0);
    push(I_WFI, 0, 0, 0, 1, 0, 0, 0);
    push(I_WFI, 0, 1, 0, 0, 0, 0, 0);
    push(I_IDLE, 0, 0, 0, 0, 0, 0, 0);
    run_expect("wfi_quit");
    check_halt("wfi_quit", 2'd1);
  endtask

  task automatic test_reset_mid_ma();
    push(I_IDLE, 0, 0, 1, 0, 0, 0, 0);
    push(I_PC, 0, 0, 0, 0, 0, 0, 0);
    push(I_IF, 0, 0, 0, 0, 0, 0, 0);
    push(I_DC, 0, 0, 0, 0, 0, 0, 0);
    push(I_EX, 0, 0, 0, 0, 0, 0, 0);
    push(I_MA, 1, 0, 0, 0, 0, 0, 0);
    run_expect("reset_mid_ma");
    #2;
    rst_n = 0;
    #1;
    tests++;
    if (vec !== 8'b0000_0001 || vec4 !== 8'b0000_0001 || retire !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_ma abort: got %b ret %b want 00000001 ret 0", vec, retire);
    end
    tests++;
    if (instret !== 32'd0 || instret4 !== 4'd0) begin
      fails++;
      $display("FAIL reset_mid_ma instret: got %0d want 0", instret);
    end
    check_halt("reset_mid_ma", 2'd0);
    @(negedge clk);
    rst_n = 1;
    ret_exp = 0;
    tick();
    tick();
    tests++;
    if (vec !== 8'b0000_0001 || instret !== 32'd0) begin
      fails++;
      $display("FAIL after_reset idle: got %b instret %0d want 00000001 instret 0", vec, instret);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_start_basic();
    test_stall();
    test_quit_in_idle();
    test_step();
    test_ebreak();
    test_wfi();
    test_back_to_back();
    test_wfi_quit();
    test_reset_mid_ma();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
